// File: rtl/ttpu_pkg.sv
// Shared types and helpers for the matrix skew feeder.
// Holds the sequencing FSM state encoding and the width rule for the
// diagonal step counter so every file agrees on both.
package ttpu_pkg;

  // Sequencer states: waiting for start, streaming diagonals, completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_t;

  // An N x N matrix has 2N-1 diagonals, so the step counter must hold 0..2N-2.
  function automatic int step_width(input int n);
    return $clog2(2 * n - 1);
  endfunction

endpackage

// File: rtl/matrix_skew_feeder_if.sv
// Output stream of the matrix skew feeder.
//
// Handshake: the feeder (master) raises out_valid while it holds a diagonal
// beat on vector_out/lane_valid/out_last. The beat transfers on a rising clk
// edge where out_valid && out_ready are both 1. While out_valid=1 and
// out_ready=0 the master keeps vector_out, lane_valid and out_last stable.
// out_ready may be driven freely by the consumer; it never feeds back
// combinationally into any master output.
//
// state mirrors the feeder's FSM register for observation only.
interface matrix_skew_feeder_if
  import ttpu_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 16
);

  logic [N-1:0][W-1:0] vector_out;
  logic [N-1:0]        lane_valid;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  feeder_state_t       state;

  modport master (
    output vector_out,
    output lane_valid,
    output out_valid,
    output out_last,
    output state,
    input  out_ready
  );

  modport slave (
    input  vector_out,
    input  lane_valid,
    input  out_valid,
    input  out_last,
    input  state,
    output out_ready
  );

endinterface

// File: rtl/diag_lane_select.sv
// Combinational diagonal element select for one output lane.
// Lane i on step k shows element k-i of its row (normal) or of its column
// (transposed). When k-i falls outside 0..N-1 the lane is padding and
// outputs zero with valid low. The subtraction is unsigned, so the k < i
// case is caught explicitly instead of relying on wrap-around.
module diag_lane_select
  import ttpu_pkg::*;
#(
  parameter int N    = 16,
  parameter int W    = 16,
  parameter int LANE = 0,
  parameter int SW   = step_width(N)
) (
  input  logic                active,
  input  logic                transpose,
  input  logic [SW-1:0]       step,
  input  logic [N-1:0][W-1:0] row,
  input  logic [N-1:0][W-1:0] col,
  output logic [W-1:0]        data,
  output logic                valid
);

  localparam int            IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LANE_S = SW'(LANE);
  localparam logic [SW-1:0] N_S    = SW'(N);

  logic [SW-1:0] offset;
  logic [IW-1:0] idx;

  // Pick row[k-i] or col[k-i] when the offset lands inside the matrix.
  always_comb begin
    offset = step - LANE_S;
    idx    = offset[IW-1:0];
    valid  = active && (step >= LANE_S) && (offset < N_S);
    data   = '0;
    if (valid) begin
      data = transpose ? col[idx] : row[idx];
    end
  end

endmodule

// File: rtl/matrix_skew_feeder.sv
// Matrix skew feeder.
// On an accepted start the whole N x N matrix and the transpose flag are
// captured; the block then streams the 2N-1 anti-diagonals one beat per
// transfer, lane i delayed by i steps, which is the skewed wavefront a
// systolic array expects. Output data comes only from the captured copy and
// the step register, so matrix_in never reaches vector_out combinationally
// and may change freely while a sequence runs.
module matrix_skew_feeder
  import ttpu_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        transpose,
  input  logic [N-1:0][N-1:0][W-1:0]  matrix_in,
  output logic                        busy,
  output logic                        done,
  matrix_skew_feeder_if.master        out_if
);

  localparam int            SW        = step_width(N);
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * N - 2);

  feeder_state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          capture;

  logic [N-1:0][N-1:0][W-1:0] mat_q;
  logic                       tr_q;

  logic                in_run;
  logic [N-1:0][W-1:0] lane_data;
  logic [N-1:0]        lane_ok;

  // FSM state and diagonal step register; reset returns to an idle, zeroed block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Captured matrix and mode; only written on an accepted start in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q <= '0;
      tr_q  <= 1'b0;
    end else if (capture) begin
      mat_q <= matrix_in;
      tr_q  <= transpose;
    end
  end

  // Next-state logic: abort outranks both start and a beat transfer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // start together with abort is a no-op, nothing is captured.
        if (start && !abort) begin
          capture = 1'b1;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (out_if.out_ready) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      ST_DONE: begin
        // Single-cycle completion state; start is not looked at here.
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  assign in_run = (state_q == ST_RUN);

  // One diagonal selector per lane; lane g reads row g or column g of the capture.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N-1:0][W-1:0] col;

    // Gather column g of the captured matrix for transposed mode.
    always_comb begin
      col = '0;
      for (int r = 0; r < N; r++) begin
        col[r] = mat_q[r][g];
      end
    end

    diag_lane_select #(
      .N    (N),
      .W    (W),
      .LANE (g),
      .SW   (SW)
    ) u_sel (
      .active    (in_run),
      .transpose (tr_q),
      .step      (step_q),
      .row       (mat_q[g]),
      .col       (col),
      .data      (lane_data[g]),
      .valid     (lane_ok[g])
    );
  end

  // Lane outputs are gated by RUN inside the selectors, so IDLE/DONE show zeros.
  assign out_if.vector_out = lane_data;
  assign out_if.lane_valid = lane_ok;
  assign out_if.out_valid  = in_run;
  assign out_if.out_last   = in_run && (step_q == LAST_STEP);
  assign out_if.state      = state_q;
  assign busy              = in_run;
  // An abort arriving in DONE suppresses the completion pulse.
  assign done              = (state_q == ST_DONE) && !abort;

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Bench for matrix_skew_feeder at N=4, W=16.
// Expected beats come from a direct reading of the diagonal rule:
// lane i on beat k carries M[i][k-i] (or M[k-i][i]) when 0 <= k-i < N.
module tb_matrix_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NB = 2 * N - 1;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic transpose;
  mat_t matrix_in;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_errors = 0;

  matrix_skew_feeder_if #(.N(N), .W(W)) bus ();

  matrix_skew_feeder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .transpose (transpose),
    .matrix_in (matrix_in),
    .busy      (busy),
    .done      (done),
    .out_if    (bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Outputs expected whenever the block is not streaming.
  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_busy"},  busy, 1'b0);
    check_eq({tag, "_vec"},   bus.vector_out, '0);
    check_eq({tag, "_mask"},  bus.lane_valid, '0);
    check_eq({tag, "_last"},  bus.out_last, 1'b0);
  endtask

  // Reference model: beat k of the skewed stream.
  function automatic void model(input mat_t m, input logic tr, input int k,
                                output logic [N*W-1:0] vec, output logic [N-1:0] mask);
    vec  = '0;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = k - i;
      if (j >= 0 && j < N) begin
        mask[i]         = 1'b1;
        vec[i*W +: W]   = tr ? m[j][i] : m[i][j];
      end
    end
  endfunction

  function automatic mat_t ref_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = W'(16 * i + j);
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = W'($urandom_range(0, 65535));
    return m;
  endfunction

  // Driver: one start plus the full beat stream; entered and left just after a rising edge.
  task automatic run_seq(input mat_t m, input logic tr, input int stall_pct,
                         input int stall_beat, input int abort_beat,
                         input int rst_beat, input bit hold);
    logic [N*W-1:0] ev;
    logic [N-1:0]   em;
    int  k = 0;
    int  cycles = 0;
    int  stalls = 0;
    int  stall_left = 0;
    bit  stalled_once = 1'b0;
    bit  fin = 1'b0;
    bit  aborting;

    start     = 1'b1;
    transpose = tr;
    matrix_in = m;
    abort     = 1'b0;
    @(negedge clk);
    check_quiet("pre");
    check_eq("pre_done", done, 1'b0);
    @(posedge clk); #1;
    if (!hold) begin
      // Captured copy must be unaffected by later input changes.
      start     = 1'b0;
      matrix_in = rand_mat();
      transpose = ~tr;
    end

    while (!fin && cycles < 64) begin
      if (k == stall_beat && !stalled_once) begin
        stall_left   = 3;
        stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      aborting = (k == abort_beat);
      abort    = aborting;

      if (k == rst_beat) begin
        #2 rst_n = 1'b0;
        #1;
        check_quiet("rst_async");
        check_eq("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        fin   = 1'b1;
      end else begin
        @(negedge clk);
        model(m, tr, k, ev, em);
        check_eq("beat_valid", bus.out_valid, 1'b1);
        check_eq("beat_busy",  busy, 1'b1);
        check_eq("beat_done",  done, 1'b0);
        check_eq("beat_vec",   bus.vector_out, ev);
        check_eq("beat_mask",  bus.lane_valid, em);
        check_eq("beat_last",  bus.out_last, (k == NB - 1));
        if (!bus.out_ready) stalls++;
        cycles++;
        @(posedge clk); #1;
        if (aborting) begin
          abort = 1'b0;
          @(negedge clk);
          check_quiet("abort");
          check_eq("abort_done", done, 1'b0);
          @(posedge clk); #1;
          fin = 1'b1;
        end else if (bus.out_ready) begin
          if (k == NB - 1) begin
            @(negedge clk);
            check_eq("done_pulse", done, 1'b1);
            check_quiet("done_state");
            check_eq("seq_len", cycles, NB + stalls);
            @(posedge clk); #1;
            fin = 1'b1;
          end else begin
            k++;
          end
        end
      end
    end
    check_eq("seq_finished", fin, 1'b1);
  endtask

  // Stimulus and final report
  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    transpose     = 1'b0;
    matrix_in     = '0;
    bus.out_ready = 1'b1;

    #2;
    check_quiet("reset");
    check_eq("reset_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain stream, then transposed, on the reference matrix M[i][j] = 16i + j.
    run_seq(ref_mat(), 1'b0, 0, -1, -1, -1, 1'b0);
    run_seq(ref_mat(), 1'b1, 0, -1, -1, -1, 1'b0);
    // Three-cycle stall on beat 2 stretches the sequence to 10 cycles.
    run_seq(ref_mat(), 1'b0, 0, 2, -1, -1, 1'b0);
    // Abort on beat 4, then a clean restart.
    run_seq(ref_mat(), 1'b0, 0, -1, 4, -1, 1'b0);
    run_seq(ref_mat(), 1'b1, 0, -1, -1, -1, 1'b0);

    // start together with abort in IDLE captures nothing.
    start     = 1'b1;
    abort     = 1'b1;
    matrix_in = rand_mat();
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_quiet("abort_start_noop");
    @(posedge clk); #1;

    // Asynchronous reset on beat 3, then a full sequence right after release.
    run_seq(rand_mat(), 1'b0, 0, -1, -1, 3, 1'b0);
    run_seq(ref_mat(), 1'b0, 0, -1, -1, -1, 1'b0);

    // start held high across a whole sequence: one run, then a fresh one from IDLE.
    run_seq(rand_mat(), 1'b0, 0, -1, -1, -1, 1'b1);
    run_seq(rand_mat(), 1'b1, 0, -1, -1, -1, 1'b0);

    // Random matrices, modes, back-pressure and occasional aborts.
    for (int r = 0; r < 8; r++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      run_seq(rand_mat(), 1'($urandom_range(0, 1)), 30, -1, ab, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
